fadd16_align_pipe: RTL and testbench

// - Two-stage pipelined alignment front end of the fp16 adder/FMA datapath.
// - Unpacks two IEEE binary16 operands and orders them by magnitude.
// - Right-shifts the smaller significand by the exponent difference, saturated to 15.
// - Produces guard/round bits and a sticky bit using fma16_rsh_lost_bits_mask-style masking.
// - Feeds the significand adder stage through a valid/ready handshake.

---
 rtl/fadd16_align_pipe.sv | 125 ++++++++++++
 tb/tb_fadd16_align_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fadd16_align_pipe.sv
// fp16 adder alignment front end: unpack and order both operands by magnitude, then shift the smaller one and build sticky.
// Two registered stages with valid/ready flow control. rdy_o is combinational from rdy_i, so back-to-back operation is possible.
module fadd16_align_pipe #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld_i,
   output logic             rdy_o,
   input  logic [15:0]      opa_i,
   input  logic [15:0]      opb_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             vld_o,
   input  logic             rdy_i,
   output logic [4:0]       exp_o,
   output logic [12:0]      sig_big_o,
   output logic [12:0]      sig_sml_o,
   output logic             sticky_o,
   output logic             sign_o,
   output logic             eff_sub_o,
   output logic             special_o,
   output logic [TAG_W-1:0] tag_o
);

   logic adv1, adv2;

   // stage 1 state
   logic             s1_vld;
   logic [4:0]       s1_exp;
   logic [12:0]      s1_sig_big;
   logic [12:0]      s1_ext_sml;
   logic [3:0]       s1_rsh;
   logic             s1_sign;
   logic             s1_eff_sub;
   logic             s1_special;
   logic [TAG_W-1:0] s1_tag;

   // stage 1 decode
   logic        swap;
   logic [14:0] mag_big, mag_sml;
   logic        hid_big, hid_sml;
   logic [4:0]  e_big, e_sml, diff;
   logic [3:0]  rsh;

   always_comb begin
      swap    = opb_i[14:0] > opa_i[14:0];
      mag_big = swap ? opb_i[14:0] : opa_i[14:0];
      mag_sml = swap ? opa_i[14:0] : opb_i[14:0];
      hid_big = |mag_big[14:10];
      hid_sml = |mag_sml[14:10];
      e_big   = hid_big ? mag_big[14:10] : 5'd1;
      e_sml   = hid_sml ? mag_sml[14:10] : 5'd1;
      diff    = e_big - e_sml;
      rsh     = (diff > 5'd15) ? 4'd15 : diff[3:0];
   end

   // stage 2 shift; lost-bit mask saturates to all ones once rsh reaches 13
   logic [12:0] mask;
   logic [12:0] sml_shifted;
   logic        sticky;

   always_comb begin
      mask = '0;
      for (int i = 0; i < 13; i++) begin
         mask[i] = 4'(i) < s1_rsh;
      end
      sml_shifted = s1_ext_sml >> s1_rsh;
      sticky      = |(s1_ext_sml & mask);
   end

   assign adv2  = ~vld_o | rdy_i;
   assign adv1  = ~s1_vld | adv2;
   assign rdy_o = adv1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld     <= 1'b0;
         s1_exp     <= '0;
         s1_sig_big <= '0;
         s1_ext_sml <= '0;
         s1_rsh     <= '0;
         s1_sign    <= 1'b0;
         s1_eff_sub <= 1'b0;
         s1_special <= 1'b0;
         s1_tag     <= '0;
         vld_o      <= 1'b0;
         exp_o      <= '0;
         sig_big_o  <= '0;
         sig_sml_o  <= '0;
         sticky_o   <= 1'b0;
         sign_o     <= 1'b0;
         eff_sub_o  <= 1'b0;
         special_o  <= 1'b0;
         tag_o      <= '0;
      end else begin
         if (adv1) begin
            s1_vld <= vld_i;
            if (vld_i) begin
               s1_exp     <= e_big;
               s1_sig_big <= {hid_big, mag_big[9:0], 2'b00};
               s1_ext_sml <= {hid_sml, mag_sml[9:0], 2'b00};
               s1_rsh     <= rsh;
               s1_sign    <= swap ? opb_i[15] : opa_i[15];
               s1_eff_sub <= opa_i[15] ^ opb_i[15];
               s1_special <= (&opa_i[14:10]) | (&opb_i[14:10]);
               s1_tag     <= tag_i;
            end
         end
         if (adv2) begin
            vld_o <= s1_vld;
            if (s1_vld) begin
               exp_o     <= s1_exp;
               sig_big_o <= s1_sig_big;
               sig_sml_o <= sml_shifted;
               sticky_o  <= sticky;
               sign_o    <= s1_sign;
               eff_sub_o <= s1_eff_sub;
               special_o <= s1_special;
               tag_o     <= s1_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_fadd16_align_pipe.sv
// Directed and random bench for fadd16_align_pipe with an in-order scoreboard and a reference alignment model.
module tb_fadd16_align_pipe;

   logic        clk = 1'b0;
   logic        rst_n, vld_i, rdy_o, vld_o, rdy_i;
   logic [15:0] opa_i, opb_i;
   logic [3:0]  tag_i, tag_o;
   logic [4:0]  exp_o;
   logic [12:0] sig_big_o, sig_sml_o;
   logic        sticky_o, sign_o, eff_sub_o, special_o;

   fadd16_align_pipe #(.TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .rdy_o(rdy_o),
      .opa_i(opa_i), .opb_i(opb_i), .tag_i(tag_i),
      .vld_o(vld_o), .rdy_i(rdy_i), .exp_o(exp_o),
      .sig_big_o(sig_big_o), .sig_sml_o(sig_sml_o), .sticky_o(sticky_o),
      .sign_o(sign_o), .eff_sub_o(eff_sub_o), .special_o(special_o), .tag_o(tag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  e;
      logic [12:0] big;
      logic [12:0] sml;
      logic        st, sg, es, sp;
      logic [3:0]  tag;
      bit          dc;
      bit          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   exp_t        nxt;
   exp_t        hd;
   int          cycn = 0;
   int          checks = 0;
   int          errors = 0;
   bit          lat_chk = 1'b0;
   bit          acc = 1'b0;
   bit          stalled = 1'b0;
   logic [39:0] snap;

   function automatic logic [39:0] outs();
      return {vld_o, exp_o, sig_big_o, sig_sml_o, sticky_o, sign_o, eff_sub_o, special_o, tag_o};
   endfunction

   function automatic exp_t mk(input logic [4:0] e, input logic [12:0] big, input logic [12:0] sml,
                               input logic st, input logic sg, input logic es, input logic sp,
                               input logic [3:0] tag);
      exp_t r;
      r.e = e; r.big = big; r.sml = sml; r.st = st; r.sg = sg; r.es = es; r.sp = sp;
      r.tag = tag; r.dc = sp; r.lat = 1'b0; r.acc = 0;
      return r;
   endfunction

   // reference: shift the smaller significand inside a 29-bit window; the low 16 bits catch everything lost
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
      logic [15:0] big, sml;
      logic [28:0] w;
      int          eb, es, d;
      exp_t        r;
      big = (b[14:0] > a[14:0]) ? b : a;
      sml = (b[14:0] > a[14:0]) ? a : b;
      eb  = (big[14:10] == 5'd0) ? 1 : int'(big[14:10]);
      es  = (sml[14:10] == 5'd0) ? 1 : int'(sml[14:10]);
      d   = eb - es;
      if (d > 15) d = 15;
      w = {(sml[14:10] != 5'd0), sml[9:0], 2'b00, 16'h0000};
      w = w >> d;
      r = mk(5'(eb), {(big[14:10] != 5'd0), big[9:0], 2'b00}, w[28:16], |w[15:0],
             big[15], a[15] ^ b[15], (&a[14:10]) | (&b[14:10]), tag);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [39:0] obs, input logic [39:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, req);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      acc = 1'b0;
      if (rst_n) begin
         chk("rdy_o", 40'(rdy_o), 40'((q.size() < 2) || rdy_i));
         if (vld_o) chk("vld_o_spurious", 40'(q.size() == 0), 40'(0));
         if (stalled) chk("stall_stable", outs(), snap);
         if (vld_o && rdy_i && q.size() > 0) begin
            hd = q.pop_front();
            if (hd.dc)
               chk("special", {35'd0, special_o, tag_o}, {35'd0, hd.sp, hd.tag});
            else
               chk("data", {exp_o, sig_big_o, sig_sml_o, sticky_o, sign_o, eff_sub_o, special_o, tag_o},
                   {hd.e, hd.big, hd.sml, hd.st, hd.sg, hd.es, hd.sp, hd.tag});
            if (hd.lat) chk("latency", 40'(cycn - hd.acc), 40'(2));
         end
         if (vld_i && rdy_o) begin
            nxt.acc = cycn;
            nxt.lat = lat_chk;
            q.push_back(nxt);
            acc = 1'b1;
         end
         stalled = vld_o && !rdy_i;
         snap    = outs();
      end else begin
         stalled = 1'b0;
      end
      cycn++;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag, input exp_t ex);
      opa_i = a; opb_i = b; tag_i = tag; vld_i = 1'b1; nxt = ex;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (acc) break;
      end
      if (!acc) chk("accept_timeout", 40'(0), 40'(1));
   endtask

   task automatic drain();
      vld_i = 1'b0;
      rdy_i = 1'b1;
      for (int k = 0; k < 30 && q.size() > 0; k++) cyc();
      chk("drain", 40'(q.size()), 40'(0));
   endtask

   initial begin
      logic [15:0] a, b;
      int          i;
      rst_n = 1'b0; vld_i = 1'b0; rdy_i = 1'b1;
      opa_i = '0; opb_i = '0; tag_i = '0;
      cyc(); cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_outs", outs(), 40'(0));
      chk("reset_rdy", 40'(rdy_o), 40'(1));
      @(posedge clk); #1; cycn++;

      lat_chk = 1'b1;
      send(16'h3C00, 16'h3C00, 4'h1, mk(5'd15, 13'h1000, 13'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1)); drain();
      send(16'h3C00, 16'h1401, 4'h2, mk(5'd15, 13'h1000, 13'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2)); drain();
      send(16'h1401, 16'h3C00, 4'h3, mk(5'd15, 13'h1000, 13'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3)); drain();
      send(16'h7800, 16'h3C00, 4'h4, mk(5'd30, 13'h1000, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4)); drain();
      send(16'h7800, 16'h0001, 4'h5, mk(5'd30, 13'h1000, 13'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5)); drain();
      send(16'hBC00, 16'h3C00, 4'h6, mk(5'd15, 13'h1000, 13'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6)); drain();
      send(16'h3C00, 16'hBC00, 4'h7, mk(5'd15, 13'h1000, 13'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7)); drain();
      send(16'h7C00, 16'h3C00, 4'h8, mk(5'd0, 13'h0, 13'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8)); drain();
      send(16'h0003, 16'h8001, 4'h9, mk(5'd1, 13'h000C, 13'h0004, 1'b0, 1'b0, 1'b1, 1'b0, 4'h9)); drain();

      // back-to-back stream with a downstream stall in loop cycles 3..5
      lat_chk = 1'b0;
      i = 0;
      for (int k = 0; k < 50 && i < 6; k++) begin
         rdy_i = !(k >= 3 && k <= 5);
         a = 16'h3C00 + 16'(i * 16'h0411);
         b = 16'h2400 + 16'(i * 16'h0203);
         opa_i = a; opb_i = b; tag_i = 4'(i); vld_i = 1'b1;
         nxt = model(a, b, 4'(i));
         cyc();
         if (acc) i++;
      end
      chk("stream_accepted", 40'(i), 40'(6));
      drain();

      // random traffic with random backpressure
      for (int k = 0; k < 40; k++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         rdy_i = ($urandom_range(0, 3) != 0);
         vld_i = ($urandom_range(0, 4) != 0);
         opa_i = a; opb_i = b; tag_i = 4'(k);
         nxt = model(a, b, 4'(k));
         cyc();
      end
      drain();

      // reset with two ops in flight
      rdy_i = 1'b0;
      send(16'h4000, 16'h3800, 4'hA, model(16'h4000, 16'h3800, 4'hA));
      send(16'h4400, 16'h3000, 4'hB, model(16'h4400, 16'h3000, 4'hB));
      vld_i = 1'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midreset_outs", outs(), 40'(0));
      chk("midreset_rdy", 40'(rdy_o), 40'(1));
      @(posedge clk); #1; cycn++;
      rdy_i = 1'b1;
      lat_chk = 1'b1;
      send(16'h3C00, 16'h1401, 4'hC, mk(5'd15, 13'h1000, 13'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 4'hC));
      drain();

      chk("queue_empty", 40'(q.size()), 40'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
